// File: rtl/trigger_cond.sv
// Push-button trigger conditioner: 2-FF synchroniser, counter debouncer,
// and a mode FSM that presents the debounced press to the core as a
// level, a stretched pulse, or a sticky event cleared by trig_ack.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | no event in progress; in level modes trigger follows deb
// HOLD    | mode 01: stretched pulse active, hold_cnt counts down
// LATCHED | mode 10: sticky event waiting for trig_ack
module trigger_cond #(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned HOLD_CYCLES     = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_in,
  input  logic [1:0] mode,
  input  logic       trig_ack,
  output logic       trigger,
  output logic       btn_level,
  output logic [7:0] event_count
);

  localparam logic [15:0] DEB_TC  = 16'(DEBOUNCE_CYCLES - 1);
  localparam logic [15:0] HOLD_LD = 16'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HOLD    = 2'd1,
    LATCHED = 2'd2
  } state_t;

  logic        s1, s2, deb;
  logic [15:0] deb_cnt, deb_cnt_nxt;
  logic        deb_nxt, mismatch, deb_accept, rise;
  logic [15:0] hold_cnt, hold_nxt;
  logic [1:0]  mode_q;
  state_t      state, state_nxt;
  logic        trig_nxt;

  // Debounce decision: accept s2 only after DEBOUNCE_CYCLES mismatching
  // cycles in a row; any return to deb restarts the count from zero.
  always_comb begin
    mismatch    = (s2 != deb);
    deb_accept  = mismatch && (deb_cnt == DEB_TC);
    deb_nxt     = deb_accept ? s2 : deb;
    deb_cnt_nxt = (!mismatch || deb_accept) ? 16'd0 : deb_cnt + 16'd1;
    rise        = deb_accept && s2;
  end

  // Synchroniser and debouncer registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1      <= 1'b0;
      s2      <= 1'b0;
      deb     <= 1'b0;
      deb_cnt <= 16'd0;
    end else begin
      s1      <= btn_in;
      s2      <= s1;
      deb     <= deb_nxt;
      deb_cnt <= deb_cnt_nxt;
    end
  end

  assign btn_level = deb;

  // Press counter and registered mode; counts in every mode, wraps at 256.
  always_ff @(posedge clk) begin
    if (rst) begin
      event_count <= 8'd0;
      mode_q      <= 2'b00;
    end else begin
      mode_q <= mode;
      if (rise) event_count <= event_count + 8'd1;
    end
  end

  // FSM state, hold counter and trigger registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      hold_cnt <= 16'd0;
      trigger  <= 1'b0;
    end else begin
      state    <= state_nxt;
      hold_cnt <= hold_nxt;
      trigger  <= trig_nxt;
    end
  end

  // Next-state logic. A mode change parks the FSM in IDLE with trigger low
  // for one edge so a half-finished event never leaks into the new mode.
  // A rise coincident with trig_ack keeps LATCHED so the new press is kept.
  always_comb begin
    state_nxt = state;
    hold_nxt  = hold_cnt;
    trig_nxt  = trigger;
    if (mode != mode_q) begin
      state_nxt = IDLE;
      trig_nxt  = 1'b0;
    end else begin
      case (mode)
        2'b01: begin
          case (state)
            IDLE: begin
              if (rise) begin
                state_nxt = HOLD;
                hold_nxt  = HOLD_LD;
                trig_nxt  = 1'b1;
              end else begin
                trig_nxt = 1'b0;
              end
            end
            HOLD: begin
              trig_nxt = 1'b1;
              if (rise) begin
                hold_nxt = HOLD_LD;
              end else if (hold_cnt != 16'd0) begin
                hold_nxt = hold_cnt - 16'd1;
              end else begin
                state_nxt = IDLE;
                trig_nxt  = 1'b0;
              end
            end
            default: begin
              state_nxt = IDLE;
              trig_nxt  = 1'b0;
            end
          endcase
        end
        2'b10: begin
          case (state)
            IDLE: begin
              if (rise) begin
                state_nxt = LATCHED;
                trig_nxt  = 1'b1;
              end else begin
                trig_nxt = 1'b0;
              end
            end
            LATCHED: begin
              if (trig_ack && !rise) begin
                state_nxt = IDLE;
                trig_nxt  = 1'b0;
              end else begin
                trig_nxt = 1'b1;
              end
            end
            default: begin
              state_nxt = IDLE;
              trig_nxt  = 1'b0;
            end
          endcase
        end
        default: begin
          state_nxt = IDLE;
          trig_nxt  = deb_nxt;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_trigger_cond.sv
// Directed bench for trigger_cond. dut uses DEBOUNCE_CYCLES=4/HOLD_CYCLES=3;
// dut_fast uses DEBOUNCE_CYCLES=1 so a re-press can land inside a hold pulse.
module tb_trigger_cond;

  logic       clk = 1'b0;
  logic       rst, btn_in, trig_ack;
  logic [1:0] mode;
  logic       trigger, btn_level;
  logic [7:0] event_count;

  logic       rst2, btn2, ack2;
  logic [1:0] mode2;
  logic       trig2, lvl2;
  logic [7:0] ev2;

  int total = 0;
  int bad   = 0;
  int hi_cnt;

  always #5 clk = ~clk;

  trigger_cond #(.DEBOUNCE_CYCLES(4), .HOLD_CYCLES(3)) dut (
    .clk(clk), .rst(rst), .btn_in(btn_in), .mode(mode), .trig_ack(trig_ack),
    .trigger(trigger), .btn_level(btn_level), .event_count(event_count)
  );

  trigger_cond #(.DEBOUNCE_CYCLES(1), .HOLD_CYCLES(3)) dut_fast (
    .clk(clk), .rst(rst2), .btn_in(btn2), .mode(mode2), .trig_ack(ack2),
    .trigger(trig2), .btn_level(lvl2), .event_count(ev2)
  );

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one edge; inputs change and outputs are sampled 1ns after it.
  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; btn_in = 1'b0; trig_ack = 1'b0; mode = 2'b00;
    rst2 = 1'b1; btn2 = 1'b0; ack2 = 1'b0; mode2 = 2'b01;
    tick(2);
    chk("rst_trigger", 16'(trigger), 16'd0);
    chk("rst_level", 16'(btn_level), 16'd0);
    chk("rst_count", 16'(event_count), 16'd0);
    rst = 1'b0;

    // 1: mode 00 press and release, 6-edge latency both ways
    btn_in = 1'b1;
    tick(5);
    chk("t1_lvl_e5", 16'(btn_level), 16'd0);
    chk("t1_trg_e5", 16'(trigger), 16'd0);
    tick();
    chk("t1_lvl_e6", 16'(btn_level), 16'd1);
    chk("t1_trg_e6", 16'(trigger), 16'd1);
    chk("t1_cnt", 16'(event_count), 16'd1);
    tick(14);
    btn_in = 1'b0;
    tick(5);
    chk("t1_rel_lvl_e5", 16'(btn_level), 16'd1);
    chk("t1_rel_trg_e5", 16'(trigger), 16'd1);
    tick();
    chk("t1_rel_lvl_e6", 16'(btn_level), 16'd0);
    chk("t1_rel_trg_e6", 16'(trigger), 16'd0);
    chk("t1_cnt_end", 16'(event_count), 16'd1);

    // 2: 3-cycle glitch is rejected
    do_reset();
    btn_in = 1'b1;
    tick(3);
    btn_in = 1'b0;
    hi_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (btn_level || trigger) hi_cnt++;
    end
    chk("t2_glitch_hi", 16'(hi_cnt), 16'd0);
    chk("t2_cnt", 16'(event_count), 16'd0);

    // 3: mode 01 stretched pulse of 3 cycles
    do_reset();
    mode = 2'b01;
    btn_in = 1'b1;
    tick(5);
    chk("t3_trg_e5", 16'(trigger), 16'd0);
    tick();
    chk("t3_trg_e6", 16'(trigger), 16'd1);
    tick();
    chk("t3_trg_e7", 16'(trigger), 16'd1);
    tick();
    chk("t3_trg_e8", 16'(trigger), 16'd1);
    tick();
    chk("t3_trg_e9", 16'(trigger), 16'd0);
    chk("t3_lvl_e9", 16'(btn_level), 16'd1);
    hi_cnt = 0;
    for (int i = 0; i < 11; i++) begin
      tick();
      if (trigger) hi_cnt++;
    end
    chk("t3_trg_after", 16'(hi_cnt), 16'd0);
    chk("t3_lvl_held", 16'(btn_level), 16'd1);
    btn_in = 1'b0;
    tick(8);
    chk("t3_rel_trg", 16'(trigger), 16'd0);

    // 3b: re-press on dut_fast extends the pulse to 3 cycles from second rise
    rst2 = 1'b0;
    btn2 = 1'b1;
    tick();
    btn2 = 1'b0;
    tick();
    btn2 = 1'b1;
    tick();
    chk("t3b_trg_e3", 16'(trig2), 16'd1);
    tick();
    chk("t3b_trg_e4", 16'(trig2), 16'd1);
    tick();
    chk("t3b_trg_e5", 16'(trig2), 16'd1);
    chk("t3b_cnt_e5", 16'(ev2), 16'd2);
    tick();
    chk("t3b_trg_e6", 16'(trig2), 16'd1);
    tick();
    chk("t3b_trg_e7", 16'(trig2), 16'd1);
    tick();
    chk("t3b_trg_e8", 16'(trig2), 16'd0);

    // 4: mode 10 sticky event, ack, ack coincident with new rise
    do_reset();
    mode = 2'b10;
    btn_in = 1'b1;
    tick(6);
    chk("t4_latch", 16'(trigger), 16'd1);
    tick(4);
    btn_in = 1'b0;
    hi_cnt = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (trigger) hi_cnt++;
    end
    chk("t4_sticky50", 16'(hi_cnt), 16'd50);
    chk("t4_lvl_rel", 16'(btn_level), 16'd0);
    trig_ack = 1'b1;
    tick();
    trig_ack = 1'b0;
    chk("t4_ack_drop", 16'(trigger), 16'd0);
    trig_ack = 1'b1;
    tick();
    trig_ack = 1'b0;
    chk("t4_ack_idle", 16'(trigger), 16'd0);
    btn_in = 1'b1;
    tick(6);
    chk("t4_latch2", 16'(trigger), 16'd1);
    chk("t4_cnt2", 16'(event_count), 16'd2);
    btn_in = 1'b0;
    tick(8);
    btn_in = 1'b1;
    tick(5);
    trig_ack = 1'b1;
    tick();
    trig_ack = 1'b0;
    chk("t4_ack_rise_trg", 16'(trigger), 16'd1);
    chk("t4_ack_rise_cnt", 16'(event_count), 16'd3);
    tick(3);
    chk("t4_still_latched", 16'(trigger), 16'd1);

    // 5: reset while LATCHED, then fresh 6-edge latency
    btn_in = 1'b0;
    tick(8);
    trig_ack = 1'b1;
    tick();
    trig_ack = 1'b0;
    btn_in = 1'b1;
    tick(6);
    chk("t5_latched", 16'(trigger), 16'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t5_rst_trg", 16'(trigger), 16'd0);
    chk("t5_rst_lvl", 16'(btn_level), 16'd0);
    chk("t5_rst_cnt", 16'(event_count), 16'd0);
    tick(5);
    chk("t5_lvl_e5", 16'(btn_level), 16'd0);
    tick();
    chk("t5_lvl_e6", 16'(btn_level), 16'd1);
    chk("t5_trg_e6", 16'(trigger), 16'd1);
    chk("t5_cnt_e6", 16'(event_count), 16'd1);

    // 6: 256 presses wrap the counter; mode switch mid-HOLD
    btn_in = 1'b0;
    mode = 2'b00;
    do_reset();
    for (int p = 1; p <= 256; p++) begin
      btn_in = 1'b1;
      tick(6);
      btn_in = 1'b0;
      tick(6);
      if (p == 255) chk("t6_cnt255", 16'(event_count), 16'd255);
    end
    chk("t6_cnt_wrap", 16'(event_count), 16'd0);
    mode = 2'b01;
    tick(2);
    btn_in = 1'b1;
    tick(6);
    chk("t6_hold_trg", 16'(trigger), 16'd1);
    mode = 2'b00;
    tick();
    chk("t6_switch_trg", 16'(trigger), 16'd0);
    chk("t6_switch_lvl", 16'(btn_level), 16'd1);
    tick();
    chk("t6_follow_trg", 16'(trigger), 16'd1);
    mode = 2'b11;
    tick();
    chk("t6_m11_switch", 16'(trigger), 16'd0);
    tick();
    chk("t6_m11_follow", 16'(trigger), 16'd1);
    btn_in = 1'b0;
    tick(6);
    chk("t6_m11_release", 16'(trigger), 16'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/trigger_cond.md
Name: trigger_cond

Overview:
Conditions the raw push-button trigger before it reaches the CPU core's `trigger` input. Stages:
- 2-FF synchroniser
- counter-based debouncer
- small mode FSM that presents the debounced signal as a level, a stretched pulse, or a sticky event cleared by acknowledge

It also keeps a wrap-around count of debounced presses for test and observability. It sits directly upstream of the core top level, with its `trigger` output wired straight to the core's `trigger` input.

Parameters:
- DEBOUNCE_CYCLES, 16: consecutive stable cycles required to accept a new button value; legal range 1 to 65535.
- HOLD_CYCLES, 8: width of the stretched pulse in mode 01, in clk cycles; legal range 1 to 65535.

Ports:
- clk  in  1  system clock (single clock domain).
- rst  in  1  synchronous reset, active-high.
- btn_in  in  1  raw asynchronous button input.
- mode  in  2  00 level, 01 stretched pulse, 10 sticky until ack, 11 reserved (behaves as 00).
- trig_ack  in  1  clears the sticky event in mode 10; ignored in other modes.
- trigger  out  1  conditioned trigger to the core.
- btn_level  out  1  debounced button level.
- event_count  out  8  number of debounced rising edges, modulo 256.

Behaviour:
- Reset: all outputs and state are cleared at the rising edge of clk while rst=1. This covers s1, s2, deb, the debounce counter, the hold counter, FSM = IDLE, trigger = 0, btn_level = 0, event_count = 0 and mode_q = 0. Reset mid-operation (any state) has the same effect.
- Synchroniser: s1 <= btn_in, s2 <= s1.
- Debouncer:
  - If s2 == deb, the counter clears to 0.
  - Otherwise the counter increments.
  - When the counter == DEBOUNCE_CYCLES-1 and s2 != deb, deb <= s2 and the counter <= 0.
  - btn_level = deb (registered).
- Latency: a btn_in change set up before edge k appears on btn_level after edge k+1+DEBOUNCE_CYCLES. Total is 2+DEBOUNCE_CYCLES edges.
- Glitch rejection: any mismatch run shorter than DEBOUNCE_CYCLES is discarded, and the counter restarts at 0 when s2 returns to deb.
- rise: an internal strobe, true on the edge where deb updates 0->1. fall: true on the edge where deb updates 1->0.
- event_count increments on every rise and wraps 255 -> 0. It counts in all modes.
- Mode change detection: mode is registered into mode_q. On any edge where mode != mode_q, the FSM goes to IDLE and trigger <= 0 for that edge; the new mode applies from the next edge.
- FSM states: IDLE, HOLD, LATCHED. trigger is registered and asserts on the same edge as btn_level in every mode.
- Mode 00/11:
  - The FSM stays in IDLE.
  - trigger <= next value of deb, so trigger always equals btn_level.
- Mode 01:
  - IDLE + rise -> HOLD, trigger <= 1, hold counter <= HOLD_CYCLES-1.
  - HOLD with hold counter > 0 -> decrement.
  - HOLD with hold counter == 0 and no rise -> IDLE, trigger <= 0.
  - rise while in HOLD reloads the hold counter to HOLD_CYCLES-1 (retrigger extends the pulse).
  - Result: trigger is high for exactly HOLD_CYCLES cycles per isolated press, independent of press length.
- Mode 10:
  - IDLE + rise -> LATCHED, trigger <= 1.
  - LATCHED + trig_ack=1 and no rise -> IDLE, trigger <= 0.
  - LATCHED + trig_ack and rise on the same edge -> remain LATCHED, trigger stays 1; the new press must not be lost.
  - trig_ack in IDLE has no effect.
- Release (fall) never affects trigger in modes 01 and 10.
- Counter widths: debounce counter and hold counter are 16 bits. Arithmetic is unsigned, with no overflow possible given the parameter ranges.

Test Plan:
Benches 1-6 use DEBOUNCE_CYCLES=4, HOLD_CYCLES=3.
1. Mode 00, reset, then btn_in 0->1 before edge 1, held 20 cycles, then released:
   - btn_level and trigger go to 1 after edge 6.
   - Both return to 0 six edges after release.
   - event_count=1.
2. Mode 00, btn_in high for 3 cycles then low (glitch):
   - btn_level, trigger and event_count remain 0 throughout.
3. Mode 01, btn_in held high 20 cycles:
   - trigger high for exactly 3 cycles starting with btn_level's rise.
   - btn_level stays 1 for the full hold.
   - A second press during the 3 cycles is impossible by debounce, so verify with DEBOUNCE_CYCLES=1: a re-press extends the pulse to 3 cycles from the second rise.
4. Mode 10, press and release:
   - trigger stays 1 for 50 cycles with no ack.
   - A trig_ack pulse drops trigger on the following edge.
   - Repeat with trig_ack coincident with a new rise: trigger stays 1 and event_count increments.
5. Mode 10, LATCHED, assert rst for one edge:
   - trigger, btn_level and event_count are all 0 after that edge.
   - A subsequent btn_in=1 is accepted after a fresh 6-edge latency.
6. 256 debounced presses in mode 00:
   - event_count reads 255 after the 255th press and 0 after the 256th.
   - Switching mode 01->00 mid-HOLD forces trigger to 0 for one edge, after which it follows btn_level.
